pwm_fade_channel: RTL and testbench
===================================

// Module: pwm_fade_channel
// PURPOSE
//  Downstream consumer of the 8-bit colour-level register. Turns the stored level (target_duty)
//  into a PWM drive for one LED channel; three instances make one RGB pixel.
//  Duty changes only on PWM period boundaries, so an update never glitches mid-period.
//  Optional fade: current duty ramps by one LSB every FADE_PERIODS periods toward the target.
// PARAMETERS
//  WIDTH         8  duty/counter width; PWM period = 2**WIDTH ticks
//  PRESCALE      4  clk cycles per PWM tick (>=1; 1 = tick every clk)
//  FADE_PERIODS  2  PWM periods per fade step (>=1)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  enable        in   1      1 = run; 0 = counters cleared and held, output low
//  fade_en       in   1      1 = ramp toward target; 0 = jump to target at next boundary
//  target_duty   in   WIDTH  requested level, sampled only at period boundaries
//  pwm_out       out  1      PWM drive to LED
//  cur_duty      out  WIDTH  duty currently applied
//  busy          out  1      1 while a fade is in progress (state != IDLE)
//  period_start  out  1      1-clk pulse, first clk of each new period
// BEHAVIOUR
//  Reset (rst_n=0, async): pre_cnt=0, pwm_cnt=0, fade_cnt=0, cur_duty=0, state=IDLE,
//   pwm_out=0, busy=0, period_start=0. Registers are released on the first clk edge after rst_n rises.
//  Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = enable && pre_cnt==PRESCALE-1.
//  pwm_cnt: +1 on each tick; wraps 2**WIDTH-1 -> 0. boundary = tick && pwm_cnt==2**WIDTH-1.
//  period_start: registered from boundary, so it is high in the clk where pwm_cnt first reads 0.
//   It is not asserted for the first period after reset or after enable rises.
//  pwm_out = enable && (pwm_cnt < cur_duty), from registers, with no extra latency.
//   Duty 0 gives always low; duty 2**WIDTH-1 gives high for 2**WIDTH-1 of 2**WIDTH ticks.
//  enable=0: pre_cnt, pwm_cnt and fade_cnt are cleared and held; pwm_out=0 and period_start=0.
//   cur_duty and state hold their values. Counting restarts from 0 when enable returns to 1.
//  cur_duty, state and fade_cnt change only at a boundary:
//   fade_en=0: cur_duty<=target_duty, state<=IDLE, fade_cnt<=0.
//   fade_en=1, IDLE: if target>cur go to UP; if target<cur go to DOWN; fade_cnt<=0.
//    No step is taken in this boundary.
//   fade_en=1, UP: if target<=cur (retarget), go to DOWN (target<cur) or IDLE (equal),
//    fade_cnt<=0, no step. Otherwise, if fade_cnt==FADE_PERIODS-1: cur_duty<=cur+1 and
//    fade_cnt<=0, going to IDLE when cur+1==target. Else fade_cnt<=fade_cnt+1.
//   fade_en=1, DOWN: mirror image of UP (step -1, retarget when target>=cur).
//  cur_duty never passes the target, so it cannot wrap below 0 or above 2**WIDTH-1.
//  busy = (state != IDLE), registered.
//  State encoding: IDLE=2'b00, UP=2'b01, DOWN=2'b10; 2'b11 recovers to IDLE at the next clk.
//  Reset mid-fade aborts immediately: cur_duty=0, IDLE, and pwm_out goes low asynchronously.
// TESTING
//  T1 PRESCALE=1, fade_en=0, target=64 from reset: boundary at clk 256. Then period_start
//   pulses every 256 clk and pwm_out is high 64 clk / low 192 clk per period.
//  T2 PRESCALE=1, FADE_PERIODS=2, fade_en=1, target 0->3: UP after boundary 1.
//   cur_duty = 1, 2, 3 after boundaries 3, 5, 7. busy drops after boundary 7.
//  T3 Retarget: during an UP ramp at cur=2, set target=0. Next boundary goes to DOWN with no step.
//   cur reaches 1 then 0 on successive step boundaries, then IDLE.
//  T4 Extremes: target=0 gives pwm_out never high. target=255 gives exactly one low tick per period.
//   PRESCALE=4 stretches every width by 4 clk.
//  T5 Change target mid-period: pwm_out pattern is unchanged until the next period_start.
//  T6 Assert rst_n=0 mid-fade, and separately drop enable for 10 clk: all outputs reset as specified.
//   With enable, cur_duty is retained and the period restarts from pwm_cnt=0.

Source files
------------

// File: rtl/pwm_fade_channel.sv
// ============================================================================
// Module      : pwm_fade_channel
// Description : One LED channel PWM driver; duty updates (jump or one-LSB fade
//               steps) are applied only on PWM period boundaries.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pwm_fade_channel #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 4,
    parameter int FADE_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fade_en,
    input  logic [WIDTH-1:0] target_duty,
    output logic             pwm_out,
    output logic [WIDTH-1:0] cur_duty,
    output logic             busy,
    output logic             period_start
);

    localparam int c_PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_MAX  = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_FADE_W-1:0] c_FADE_MAX = c_FADE_W'(FADE_PERIODS - 1);
    localparam logic [WIDTH-1:0]    c_CNT_MAX  = '1;

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_UP   = 2'b01;
    localparam logic [1:0] c_ST_DOWN = 2'b10;

    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic [WIDTH-1:0]    r_pwm_cnt;
    logic [c_FADE_W-1:0] r_fade_cnt;
    logic [WIDTH-1:0]    r_cur_duty;
    logic [1:0]          r_state;
    logic                r_period_start;

    logic                w_tick;
    logic                w_boundary;
    logic                w_fade_last;
    logic [1:0]          w_nxt_state;
    logic [WIDTH-1:0]    w_nxt_cur;
    logic [c_FADE_W-1:0] w_nxt_fade;

    assign w_tick      = enable && (r_pre_cnt == c_PRE_MAX);
    assign w_boundary  = w_tick && (r_pwm_cnt == c_CNT_MAX);
    assign w_fade_last = (r_fade_cnt == c_FADE_MAX);

    // Timebase: held at zero while disabled so a re-enable starts a clean period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else if (!enable) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pre_cnt      <= (r_pre_cnt == c_PRE_MAX) ? '0 : r_pre_cnt + c_PRE_W'(1);
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + WIDTH'(1);
            end
            r_period_start <= w_boundary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cur_duty <= '0;
            r_fade_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cur_duty <= w_nxt_cur;
            r_fade_cnt <= enable ? w_nxt_fade : '0;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur_duty;
        w_nxt_fade  = r_fade_cnt;
        if (r_state != c_ST_IDLE && r_state != c_ST_UP && r_state != c_ST_DOWN) begin
            w_nxt_state = c_ST_IDLE;
        end else if (w_boundary) begin
            if (!fade_en) begin
                w_nxt_cur   = target_duty;
                w_nxt_state = c_ST_IDLE;
                w_nxt_fade  = '0;
            end else begin
                case (r_state)
                    c_ST_UP: begin
                        // A target at or below the current level reverses without stepping.
                        if (target_duty <= r_cur_duty) begin
                            w_nxt_state = (target_duty < r_cur_duty) ? c_ST_DOWN : c_ST_IDLE;
                            w_nxt_fade  = '0;
                        end else if (w_fade_last) begin
                            w_nxt_cur  = r_cur_duty + WIDTH'(1);
                            w_nxt_fade = '0;
                            if (r_cur_duty + WIDTH'(1) == target_duty) begin
                                w_nxt_state = c_ST_IDLE;
                            end
                        end else begin
                            w_nxt_fade = r_fade_cnt + c_FADE_W'(1);
                        end
                    end
                    c_ST_DOWN: begin
                        if (target_duty >= r_cur_duty) begin
                            w_nxt_state = (target_duty > r_cur_duty) ? c_ST_UP : c_ST_IDLE;
                            w_nxt_fade  = '0;
                        end else if (w_fade_last) begin
                            w_nxt_cur  = r_cur_duty - WIDTH'(1);
                            w_nxt_fade = '0;
                            if (r_cur_duty - WIDTH'(1) == target_duty) begin
                                w_nxt_state = c_ST_IDLE;
                            end
                        end else begin
                            w_nxt_fade = r_fade_cnt + c_FADE_W'(1);
                        end
                    end
                    default: begin
                        w_nxt_fade = '0;
                        if (target_duty > r_cur_duty) begin
                            w_nxt_state = c_ST_UP;
                        end else if (target_duty < r_cur_duty) begin
                            w_nxt_state = c_ST_DOWN;
                        end
                    end
                endcase
            end
        end
    end

    assign pwm_out      = enable && (r_pwm_cnt < r_cur_duty);
    assign cur_duty     = r_cur_duty;
    assign busy         = (r_state != c_ST_IDLE);
    assign period_start = r_period_start;

endmodule

`default_nettype wire

// File: tb/tb_pwm_fade_channel.sv
// ============================================================================
// Module      : tb_pwm_fade_channel
// Description : Directed self-checking bench for pwm_fade_channel (PRESCALE 1
//               and PRESCALE 4 instances sharing the same stimulus).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_fade_channel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fade_en = 1'b0;
    logic [7:0] target_duty = 8'd0;

    logic       pwm_out, busy, period_start;
    logic [7:0] cur_duty;
    logic       pwm_out4, busy4, period_start4;
    logic [7:0] cur_duty4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_fade_channel #(.WIDTH(8), .PRESCALE(1), .FADE_PERIODS(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fade_en(fade_en),
        .target_duty(target_duty), .pwm_out(pwm_out), .cur_duty(cur_duty),
        .busy(busy), .period_start(period_start)
    );

    pwm_fade_channel #(.WIDTH(8), .PRESCALE(4), .FADE_PERIODS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fade_en(fade_en),
        .target_duty(target_duty), .pwm_out(pwm_out4), .cur_duty(cur_duty4),
        .busy(busy4), .period_start(period_start4)
    );

    // Leaves the bench on the negedge where rst_n rises; the next posedge is clk 1.
    task automatic do_reset(input logic [7:0] tgt, input logic fe);
        enable      = 1'b1;
        fade_en     = fe;
        target_duty = tgt;
        rst_n       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1; fade_en = 1'b0; target_duty = 8'd64; rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({pwm_out, cur_duty, busy, period_start} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {pwm_out, cur_duty, busy, period_start});
        end
        n_cmp++;
        if ({pwm_out4, cur_duty4, busy4, period_start4} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got %b expected 0", {pwm_out4, cur_duty4, busy4, period_start4});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_period();
        int ps_cnt, hi_cnt, bad;
        do_reset(8'd64, 1'b0);
        ps_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (period_start) ps_cnt++;
        end
        n_cmp++;
        if (ps_cnt !== 0) begin
            n_fail++; $display("FAIL t1_no_first_ps: got %0d pulses expected 0", ps_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (period_start !== 1'b1 || cur_duty !== 8'd64) begin
            n_fail++; $display("FAIL t1_first_boundary: got ps=%b cur=%0d expected ps=1 cur=64", period_start, cur_duty);
        end
        ps_cnt = 0; hi_cnt = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_out) hi_cnt++;
            if (pwm_out !== (i < 64)) bad++;
            if (period_start) ps_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi_cnt !== 64 || bad !== 0) begin
            n_fail++; $display("FAIL t1_duty64: got high=%0d misplaced=%0d expected high=64 misplaced=0", hi_cnt, bad);
        end
        n_cmp++;
        if (ps_cnt !== 1 || period_start !== 1'b1) begin
            n_fail++; $display("FAIL t1_ps_spacing: got %0d pulses, next ps=%b expected 1 and 1", ps_cnt, period_start);
        end
    endtask

    task automatic test_fade_up();
        int exp_cur [7] = '{0, 0, 1, 1, 2, 2, 3};
        int exp_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
        do_reset(8'd3, 1'b1);
        for (int k = 0; k < 7; k++) begin
            repeat (256) @(negedge clk);
            n_cmp++;
            if (cur_duty !== 8'(exp_cur[k]) || busy !== 1'(exp_busy[k])) begin
                n_fail++;
                $display("FAIL t2_fade_b%0d: got cur=%0d busy=%b expected cur=%0d busy=%0d",
                         k + 1, cur_duty, busy, exp_cur[k], exp_busy[k]);
            end
        end
    endtask

    task automatic test_retarget();
        int exp_cur [5] = '{2, 2, 1, 1, 0};
        int exp_busy[5] = '{1, 1, 1, 1, 0};
        do_reset(8'd3, 1'b1);
        repeat (5 * 256) @(negedge clk);
        n_cmp++;
        if (cur_duty !== 8'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL t3_pre_retarget: got cur=%0d busy=%b expected cur=2 busy=1", cur_duty, busy);
        end
        repeat (100) @(negedge clk);
        target_duty = 8'd0;
        for (int k = 0; k < 5; k++) begin
            repeat ((k == 0) ? 156 : 256) @(negedge clk);
            n_cmp++;
            if (cur_duty !== 8'(exp_cur[k]) || busy !== 1'(exp_busy[k])) begin
                n_fail++;
                $display("FAIL t3_retarget_b%0d: got cur=%0d busy=%b expected cur=%0d busy=%0d",
                         k + 6, cur_duty, busy, exp_cur[k], exp_busy[k]);
            end
        end
    endtask

    task automatic test_extremes();
        int hi_cnt, lo_cnt, ps_cnt;
        do_reset(8'd0, 1'b0);
        hi_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) hi_cnt++;
        end
        n_cmp++;
        if (hi_cnt !== 0) begin
            n_fail++; $display("FAIL t4_duty0: got %0d high samples expected 0", hi_cnt);
        end
        target_duty = 8'd255;
        repeat (256) @(negedge clk);
        lo_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_out !== 1'b1) lo_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (lo_cnt !== 1) begin
            n_fail++; $display("FAIL t4_duty255: got %0d low samples expected 1", lo_cnt);
        end
        n_cmp++;
        if (cur_duty4 !== 8'd255 || period_start4 !== 1'b1) begin
            n_fail++; $display("FAIL t4_pre4_boundary: got cur=%0d ps=%b expected cur=255 ps=1", cur_duty4, period_start4);
        end
        lo_cnt = 0; ps_cnt = 0;
        for (int j = 0; j < 1024; j++) begin
            if (pwm_out4 !== 1'b1) lo_cnt++;
            if (period_start4) ps_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (lo_cnt !== 4 || ps_cnt !== 1) begin
            n_fail++; $display("FAIL t4_pre4_duty255: got low=%0d ps=%0d expected low=4 ps=1", lo_cnt, ps_cnt);
        end
    endtask

    task automatic test_mid_period_change();
        int bad, hi_cnt;
        do_reset(8'd64, 1'b0);
        repeat (356) @(negedge clk);
        target_duty = 8'd200;
        bad = 0;
        for (int i = 0; i < 156; i++) begin
            if (pwm_out !== 1'b0 || cur_duty !== 8'd64) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL t5_no_glitch: got %0d disturbed samples expected 0", bad);
        end
        n_cmp++;
        if (cur_duty !== 8'd200 || period_start !== 1'b1) begin
            n_fail++; $display("FAIL t5_apply: got cur=%0d ps=%b expected cur=200 ps=1", cur_duty, period_start);
        end
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_out) hi_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi_cnt !== 200) begin
            n_fail++; $display("FAIL t5_duty200: got %0d high expected 200", hi_cnt);
        end
    endtask

    task automatic test_reset_and_disable();
        int bad, ps_cnt;
        do_reset(8'd3, 1'b1);
        repeat (1281) @(negedge clk);
        n_cmp++;
        if (pwm_out !== 1'b1 || busy !== 1'b1 || cur_duty !== 8'd2) begin
            n_fail++; $display("FAIL t6_midfade: got pwm=%b busy=%b cur=%0d expected 1 1 2", pwm_out, busy, cur_duty);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pwm_out, cur_duty, busy, period_start} !== 11'd0) begin
            n_fail++; $display("FAIL t6_async_reset: got %b expected 0", {pwm_out, cur_duty, busy, period_start});
        end
        @(negedge clk);
        do_reset(8'd64, 1'b0);
        repeat (266) @(negedge clk);
        n_cmp++;
        if (pwm_out !== 1'b1) begin
            n_fail++; $display("FAIL t6_pre_disable: got pwm=%b expected 1", pwm_out);
        end
        enable = 1'b0;
        target_duty = 8'd10;
        #1;
        n_cmp++;
        if (pwm_out !== 1'b0) begin
            n_fail++; $display("FAIL t6_disable_low: got pwm=%b expected 0", pwm_out);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwm_out !== 1'b0 || period_start !== 1'b0 || cur_duty !== 8'd64) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL t6_disabled_hold: got %0d bad samples expected 0", bad);
        end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (pwm_out !== 1'b1) begin
            n_fail++; $display("FAIL t6_restart_cnt0: got pwm=%b expected 1", pwm_out);
        end
        ps_cnt = 0; bad = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (period_start) ps_cnt++;
            if (cur_duty !== 8'd64) bad++;
        end
        @(negedge clk);
        n_cmp++;
        if (ps_cnt !== 0 || bad !== 0 || period_start !== 1'b1 || cur_duty !== 8'd10) begin
            n_fail++;
            $display("FAIL t6_restart_period: got early_ps=%0d bad=%0d ps=%b cur=%0d expected 0 0 1 10",
                     ps_cnt, bad, period_start, cur_duty);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_period();
        test_fade_up();
        test_retarget();
        test_extremes();
        test_mid_period_change();
        test_reset_and_disable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
